// File: rtl/urv_writeback.sv
// -----------------------------------------------------------------------------
// urv_writeback
//
// Writeback stage. It selects the result to write, aligns load data, stalls the
// pipeline while a load or store is waiting for memory, and keeps a registered
// copy of the last committed register write for the read bypass.
//
// Optional feature (macro URV_WB_BUS_TIMEOUT_EN): an 8-bit wait counter ends a
// memory wait after 255 cycles. The access is then dropped, w_bus_error_o
// pulses for one cycle, and that cycle gives no write and no stall. Without the
// macro, a wait lasts until the done strobe arrives and w_bus_error_o is 0.
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   w_valid_i/w_load_i/w_store_i instruction qualifiers from exec
//   w_rd_write_i, w_rd_i         destination write enable / register index
//   w_fun_i, w_dm_addr_i         load width code / load address (lane select)
//   w_rd_source_i                result source (1 shifter, 2 multiplier, else ALU)
//   w_rd_value_i/_shifter_i/_multiply_i  candidate results
//   dm_data_l_i                  raw load data word
//   dm_load_done_i/dm_store_done_i memory completion strobes
//   rf_rd_o/rf_rd_value_o/rf_rd_write_o   register-file write port
//   x_fwd_rd_o/x_fwd_value_o/x_fwd_valid_o  registered last write (bypass)
//   w_stall_req_o                pipeline stall request (combinational)
//   w_bus_error_o                bus timeout pulse
// -----------------------------------------------------------------------------
module urv_writeback (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        w_valid_i,
    input  logic        w_load_i,
    input  logic        w_store_i,
    input  logic        w_rd_write_i,
    input  logic [2:0]  w_fun_i,
    input  logic [4:0]  w_rd_i,
    input  logic [1:0]  w_rd_source_i,
    input  logic [31:0] w_dm_addr_i,
    input  logic [31:0] w_rd_value_i,
    input  logic [31:0] w_rd_shifter_i,
    input  logic [31:0] w_rd_multiply_i,
    input  logic [31:0] dm_data_l_i,
    input  logic        dm_load_done_i,
    input  logic        dm_store_done_i,
    output logic [4:0]  rf_rd_o,
    output logic [31:0] rf_rd_value_o,
    output logic        rf_rd_write_o,
    output logic [4:0]  x_fwd_rd_o,
    output logic [31:0] x_fwd_value_o,
    output logic        x_fwd_valid_o,
    output logic        w_stall_req_o,
    output logic        w_bus_error_o
);

    localparam logic [1:0] ST_IDLE       = 2'd0;
    localparam logic [1:0] ST_WAIT_LOAD  = 2'd1;
    localparam logic [1:0] ST_WAIT_STORE = 2'd2;

    logic [1:0]  r_state;
    logic [1:0]  w_state_next;
    logic        w_accept;
    logic        w_timeout;
    logic        w_is_load;
    logic        w_is_store;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_value;
    logic [31:0] r_fwd_value;
    logic [4:0]  r_fwd_rd;
    logic        r_fwd_valid;
    logic        w_unused_addr;

    // Only the lane bits of the load address matter here.
    assign w_unused_addr = ^w_dm_addr_i[31:2];

`ifdef URV_WB_BUS_TIMEOUT_EN
    logic [7:0] r_tmo_cnt;
    logic       r_bus_error;
    logic       w_waiting;

    assign w_waiting = ((r_state == ST_WAIT_LOAD)  & !dm_load_done_i) |
                       ((r_state == ST_WAIT_STORE) & !dm_store_done_i);
    // The counter moves to 255 on this edge, so the wait ends here.
    assign w_timeout = w_waiting & (r_tmo_cnt == 8'hFE);
    // During the error pulse exec still shows the dropped access. Ignore it so
    // it does not start a new wait or write the register file.
    assign w_accept  = !r_bus_error;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_tmo_cnt   <= 8'd0;
            r_bus_error <= 1'b0;
        end else begin
            r_bus_error <= w_timeout;
            // Held at zero in IDLE, so every wait starts counting from zero.
            if (r_state == ST_IDLE) begin
                r_tmo_cnt <= 8'd0;
            end else begin
                r_tmo_cnt <= r_tmo_cnt + 8'd1;
            end
        end
    end

    assign w_bus_error_o = r_bus_error;
`else
    assign w_timeout     = 1'b0;
    assign w_accept      = 1'b1;
    assign w_bus_error_o = 1'b0;
`endif

    // A load has priority when load and store are both set.
    assign w_is_load  = w_valid_i & w_load_i & w_accept;
    assign w_is_store = w_valid_i & w_store_i & !w_load_i & w_accept;

    // Load lane extraction and extension
    always_comb begin
        w_byte = 8'd0;
        unique case (w_dm_addr_i[1:0])
            2'd0: w_byte = dm_data_l_i[7:0];
            2'd1: w_byte = dm_data_l_i[15:8];
            2'd2: w_byte = dm_data_l_i[23:16];
            2'd3: w_byte = dm_data_l_i[31:24];
            default: w_byte = dm_data_l_i[7:0];
        endcase
        w_half = w_dm_addr_i[1] ? dm_data_l_i[31:16] : dm_data_l_i[15:0];

        case (w_fun_i)
            3'b000:  w_load_value = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_load_value = {24'd0, w_byte};
            3'b001:  w_load_value = {{16{w_half[15]}}, w_half};
            3'b101:  w_load_value = {16'd0, w_half};
            default: w_load_value = dm_data_l_i;
        endcase
    end

    // Result select
    always_comb begin
        rf_rd_value_o = w_rd_value_i;
        if (w_load_i) begin
            rf_rd_value_o = w_load_value;
        end else begin
            case (w_rd_source_i)
                2'd1:    rf_rd_value_o = w_rd_shifter_i;
                2'd2:    rf_rd_value_o = w_rd_multiply_i;
                default: rf_rd_value_o = w_rd_value_i;
            endcase
        end
    end

    assign rf_rd_o       = w_rd_i;
    assign rf_rd_write_o = w_valid_i & w_rd_write_i & (w_rd_i != 5'd0) &
                           (!w_load_i | dm_load_done_i) & w_accept;

    // Stall and next-state logic
    always_comb begin
        w_state_next  = r_state;
        w_stall_req_o = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_stall_req_o = (w_is_load & !dm_load_done_i) |
                                (w_is_store & !dm_store_done_i);
                if (w_is_load & !dm_load_done_i) begin
                    w_state_next = ST_WAIT_LOAD;
                end else if (w_is_store & !dm_store_done_i) begin
                    w_state_next = ST_WAIT_STORE;
                end
            end
            ST_WAIT_LOAD: begin
                w_stall_req_o = w_valid_i & !dm_load_done_i;
                if (dm_load_done_i | w_timeout) begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_WAIT_STORE: begin
                w_stall_req_o = w_valid_i & !dm_store_done_i;
                if (dm_store_done_i | w_timeout) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Bypass copy of the last committed write. The data is kept when the valid
    // bit drops.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_fwd_valid <= 1'b0;
            r_fwd_rd    <= 5'd0;
            r_fwd_value <= 32'd0;
        end else if (rf_rd_write_o) begin
            r_fwd_valid <= 1'b1;
            r_fwd_rd    <= rf_rd_o;
            r_fwd_value <= rf_rd_value_o;
        end else begin
            r_fwd_valid <= 1'b0;
        end
    end

    assign x_fwd_valid_o = r_fwd_valid;
    assign x_fwd_rd_o    = r_fwd_rd;
    assign x_fwd_value_o = r_fwd_value;

endmodule

// File: tb/tb_urv_writeback.sv
// -----------------------------------------------------------------------------
// tb_urv_writeback
//
// Directed self-checking bench for urv_writeback. Inputs change 1 ns after the
// rising edge. Checks run 1 ns after that, away from the edge.
// -----------------------------------------------------------------------------
module tb_urv_writeback;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        w_valid_i, w_load_i, w_store_i, w_rd_write_i;
    logic [2:0]  w_fun_i;
    logic [4:0]  w_rd_i;
    logic [1:0]  w_rd_source_i;
    logic [31:0] w_dm_addr_i, w_rd_value_i, w_rd_shifter_i, w_rd_multiply_i;
    logic [31:0] dm_data_l_i;
    logic        dm_load_done_i, dm_store_done_i;
    logic [4:0]  rf_rd_o, x_fwd_rd_o;
    logic [31:0] rf_rd_value_o, x_fwd_value_o;
    logic        rf_rd_write_o, x_fwd_valid_o, w_stall_req_o, w_bus_error_o;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk_i = ~clk_i;

    urv_writeback dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .w_valid_i       (w_valid_i),
        .w_load_i        (w_load_i),
        .w_store_i       (w_store_i),
        .w_rd_write_i    (w_rd_write_i),
        .w_fun_i         (w_fun_i),
        .w_rd_i          (w_rd_i),
        .w_rd_source_i   (w_rd_source_i),
        .w_dm_addr_i     (w_dm_addr_i),
        .w_rd_value_i    (w_rd_value_i),
        .w_rd_shifter_i  (w_rd_shifter_i),
        .w_rd_multiply_i (w_rd_multiply_i),
        .dm_data_l_i     (dm_data_l_i),
        .dm_load_done_i  (dm_load_done_i),
        .dm_store_done_i (dm_store_done_i),
        .rf_rd_o         (rf_rd_o),
        .rf_rd_value_o   (rf_rd_value_o),
        .rf_rd_write_o   (rf_rd_write_o),
        .x_fwd_rd_o      (x_fwd_rd_o),
        .x_fwd_value_o   (x_fwd_value_o),
        .x_fwd_valid_o   (x_fwd_valid_o),
        .w_stall_req_o   (w_stall_req_o),
        .w_bus_error_o   (w_bus_error_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_idle();
        w_valid_i       = 1'b0;
        w_load_i        = 1'b0;
        w_store_i       = 1'b0;
        w_rd_write_i    = 1'b0;
        w_fun_i         = 3'b000;
        w_rd_i          = 5'd0;
        w_rd_source_i   = 2'd0;
        w_dm_addr_i     = 32'd0;
        w_rd_value_i    = 32'd0;
        w_rd_shifter_i  = 32'd0;
        w_rd_multiply_i = 32'd0;
        dm_data_l_i     = 32'd0;
        dm_load_done_i  = 1'b0;
        dm_store_done_i = 1'b0;
    endtask

    // Present a load that completes in the same cycle. Check the aligned result.
    task automatic load_now(input string tag, input logic [2:0] fun, input logic [31:0] addr,
                            input logic [31:0] data, input logic [31:0] exp);
        tick();
        set_idle();
        w_valid_i = 1'b1; w_load_i = 1'b1; w_rd_write_i = 1'b1; w_rd_i = 5'd7;
        w_fun_i = fun; w_dm_addr_i = addr; dm_data_l_i = data; dm_load_done_i = 1'b1;
        #1;
        check({tag, "_value"}, rf_rd_value_o, exp);
        check({tag, "_stall"}, {31'd0, w_stall_req_o}, 32'd0);
        check({tag, "_write"}, {31'd0, rf_rd_write_o}, 32'd1);
    endtask

    initial begin
        set_idle();
        rst_i = 1'b1;
        tick();
        tick();
        #1;
        check("rst_fwd_valid", {31'd0, x_fwd_valid_o}, 32'd0);
        check("rst_fwd_rd", {27'd0, x_fwd_rd_o}, 32'd0);
        check("rst_fwd_value", x_fwd_value_o, 32'd0);
        check("rst_bus_error", {31'd0, w_bus_error_o}, 32'd0);
        check("rst_stall", {31'd0, w_stall_req_o}, 32'd0);
        rst_i = 1'b0;

        // ALU write to x5
        tick();
        w_valid_i = 1'b1; w_rd_write_i = 1'b1; w_rd_i = 5'd5; w_rd_value_i = 32'h1234;
        w_rd_shifter_i = 32'hAAAA_0001; w_rd_multiply_i = 32'h5555_0002;
        #1;
        check("alu_write", {31'd0, rf_rd_write_o}, 32'd1);
        check("alu_value", rf_rd_value_o, 32'h1234);
        check("alu_rd", {27'd0, rf_rd_o}, 32'd5);
        check("alu_stall", {31'd0, w_stall_req_o}, 32'd0);
        w_rd_source_i = 2'd1; #1;
        check("src_shifter", rf_rd_value_o, 32'hAAAA_0001);
        w_rd_source_i = 2'd2; #1;
        check("src_multiply", rf_rd_value_o, 32'h5555_0002);
        w_rd_source_i = 2'd3; #1;
        check("src_three", rf_rd_value_o, 32'h1234);
        w_rd_source_i = 2'd0;
        tick();
        set_idle();
        #1;
        check("fwd_valid", {31'd0, x_fwd_valid_o}, 32'd1);
        check("fwd_rd", {27'd0, x_fwd_rd_o}, 32'd5);
        check("fwd_value", x_fwd_value_o, 32'h1234);
        tick();
        check("fwd_valid_drop", {31'd0, x_fwd_valid_o}, 32'd0);
        check("fwd_value_held", x_fwd_value_o, 32'h1234);

        // Zero-wait loads of each width
        load_now("lb", 3'b000, 32'h0000_1003, 32'h80FF_FF00, 32'hFFFF_FF80);
        load_now("lbu", 3'b100, 32'h0000_1003, 32'h80FF_FF00, 32'h0000_0080);
        load_now("lb1", 3'b000, 32'h0000_1001, 32'h0000_7F00, 32'h0000_007F);
        load_now("lh", 3'b001, 32'h0000_1000, 32'h1234_8001, 32'hFFFF_8001);
        load_now("lhu_lo", 3'b101, 32'h0000_1000, 32'h1234_8001, 32'h0000_8001);
        load_now("lw", 3'b010, 32'h0000_1000, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        load_now("fun011", 3'b011, 32'h0000_1001, 32'hCAFE_F00D, 32'hCAFE_F00D);

        // lhu with three stall cycles
        tick();
        set_idle();
        w_valid_i = 1'b1; w_load_i = 1'b1; w_rd_write_i = 1'b1; w_rd_i = 5'd9;
        w_fun_i = 3'b101; w_dm_addr_i = 32'h0000_2002;
        #1;
        check("lhu_stall0", {31'd0, w_stall_req_o}, 32'd1);
        check("lhu_nowrite0", {31'd0, rf_rd_write_o}, 32'd0);
        for (int i = 1; i < 3; i++) begin
            tick();
            check($sformatf("lhu_stall%0d", i), {31'd0, w_stall_req_o}, 32'd1);
            check($sformatf("lhu_nowrite%0d", i), {31'd0, rf_rd_write_o}, 32'd0);
        end
        tick();
        dm_data_l_i = 32'hBEEF_0000; dm_load_done_i = 1'b1;
        #1;
        check("lhu_done_stall", {31'd0, w_stall_req_o}, 32'd0);
        check("lhu_done_write", {31'd0, rf_rd_write_o}, 32'd1);
        check("lhu_done_value", rf_rd_value_o, 32'h0000_BEEF);
        tick();
        set_idle();
        w_valid_i = 1'b1;
        #1;
        check("lhu_fwd_value", x_fwd_value_o, 32'h0000_BEEF);
        check("lhu_fwd_rd", {27'd0, x_fwd_rd_o}, 32'd9);
        check("lhu_back_idle", {31'd0, w_stall_req_o}, 32'd0);

        // Write to x0
        tick();
        set_idle();
        w_valid_i = 1'b1; w_rd_write_i = 1'b1; w_rd_i = 5'd0; w_rd_value_i = 32'hFFFF_FFFF;
        #1;
        check("x0_write", {31'd0, rf_rd_write_o}, 32'd0);
        tick();
        set_idle();
        #1;
        check("x0_fwd_valid", {31'd0, x_fwd_valid_o}, 32'd0);

        // Store with two stall cycles
        tick();
        set_idle();
        w_valid_i = 1'b1; w_store_i = 1'b1;
        #1;
        check("st_stall0", {31'd0, w_stall_req_o}, 32'd1);
        check("st_nowrite0", {31'd0, rf_rd_write_o}, 32'd0);
        tick();
        check("st_stall1", {31'd0, w_stall_req_o}, 32'd1);
        tick();
        dm_store_done_i = 1'b1;
        #1;
        check("st_done_stall", {31'd0, w_stall_req_o}, 32'd0);
        check("st_done_write", {31'd0, rf_rd_write_o}, 32'd0);
        tick();
        set_idle();
        w_valid_i = 1'b1;
        #1;
        check("st_back_idle", {31'd0, w_stall_req_o}, 32'd0);

        // Stray done strobes in IDLE are ignored
        tick();
        set_idle();
        dm_load_done_i = 1'b1; dm_store_done_i = 1'b1;
        #1;
        check("stray_stall", {31'd0, w_stall_req_o}, 32'd0);
        tick();
        set_idle();
        w_valid_i = 1'b1;
        #1;
        check("stray_idle", {31'd0, w_stall_req_o}, 32'd0);

        // Load and store together act as a load
        tick();
        set_idle();
        w_valid_i = 1'b1; w_load_i = 1'b1; w_store_i = 1'b1; w_rd_write_i = 1'b1;
        w_rd_i = 5'd3; w_fun_i = 3'b010; dm_data_l_i = 32'h0BAD_CAFE; dm_load_done_i = 1'b1;
        #1;
        check("ldst_stall", {31'd0, w_stall_req_o}, 32'd0);
        check("ldst_write", {31'd0, rf_rd_write_o}, 32'd1);
        check("ldst_value", rf_rd_value_o, 32'h0BAD_CAFE);
        tick();
        set_idle();
        w_valid_i = 1'b1;
        #1;
        check("ldst_idle", {31'd0, w_stall_req_o}, 32'd0);

        // Reset during a load wait
        tick();
        set_idle();
        w_valid_i = 1'b1; w_load_i = 1'b1; w_rd_write_i = 1'b1; w_rd_i = 5'd4;
        tick();
        rst_i = 1'b1;
        #1;
        check("rstw_stall_comb", {31'd0, w_stall_req_o}, 32'd1);
        check("rstw_nowrite", {31'd0, rf_rd_write_o}, 32'd0);
        tick();
        rst_i = 1'b0;
        set_idle();
        w_valid_i = 1'b1;
        #1;
        check("rstw_idle", {31'd0, w_stall_req_o}, 32'd0);
        check("rstw_fwd_valid", {31'd0, x_fwd_valid_o}, 32'd0);

`ifdef URV_WB_BUS_TIMEOUT_EN
        // A load that never completes times out.
        begin
            int n;
            tick();
            set_idle();
            w_valid_i = 1'b1; w_load_i = 1'b1; w_rd_write_i = 1'b1; w_rd_i = 5'd4;
            #1;
            check("tmo_stall_start", {31'd0, w_stall_req_o}, 32'd1);
            tick();
            n = 0;
            while (n < 400) begin
                tick();
                n++;
                if (w_bus_error_o) break;
            end
            check("tmo_cycles", n, 32'd255);
            check("tmo_error", {31'd0, w_bus_error_o}, 32'd1);
            check("tmo_stall_drop", {31'd0, w_stall_req_o}, 32'd0);
            check("tmo_nowrite", {31'd0, rf_rd_write_o}, 32'd0);
            set_idle();
            tick();
            check("tmo_pulse_end", {31'd0, w_bus_error_o}, 32'd0);
        end
`else
        check("no_bus_error", {31'd0, w_bus_error_o}, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/urv_writeback.md
URV_WRITEBACK -- requirements
Module: urv_writeback

Interface
REQ-001 SHALL have ports, in order: clk_i in 1 clock; rst_i in 1 synchronous active-high reset; all state on clk_i rising edge.
REQ-002 SHALL have w_valid_i, w_load_i, w_store_i, w_rd_write_i in 1 each; exec-stage qualifiers, held stable by exec while w_stall_req_o=1.
REQ-003 SHALL have w_fun_i in 3 (load width), w_rd_i in 5 (destination), w_rd_source_i in 2 (result source), w_dm_addr_i in 32 (load address).
REQ-004 SHALL have w_rd_value_i, w_rd_shifter_i, w_rd_multiply_i in 32 each; ALU/CSR, shifter and multiplier results.
REQ-005 SHALL have dm_data_l_i in 32 (load data), dm_load_done_i in 1, dm_store_done_i in 1; memory completion strobes.
REQ-006 SHALL have rf_rd_o out 5, rf_rd_value_o out 32, rf_rd_write_o out 1; register-file write port.
REQ-007 SHALL have x_fwd_rd_o out 5, x_fwd_value_o out 32, x_fwd_valid_o out 1; registered copy of last committed write, for read bypass.
REQ-008 SHALL have w_stall_req_o out 1 (pipeline stall request) and w_bus_error_o out 1 (timeout pulse).

Function
REQ-009 Result select SHALL be: w_rd_source_i=1 -> w_rd_shifter_i; 2 -> w_rd_multiply_i; 0 or 3 -> w_rd_value_i; load -> aligned load data.
REQ-010 Load alignment SHALL use w_fun_i: 000 byte signed, 100 byte unsigned, 001 half signed, 101 half unsigned, 010 word; lane from w_dm_addr_i[1:0] (byte) or [1] (half); other codes -> word.
REQ-011 FSM states SHALL be IDLE, WAIT_LOAD, WAIT_STORE; reset state IDLE.
REQ-012 IDLE: w_valid_i & w_load_i & !dm_load_done_i -> WAIT_LOAD; w_valid_i & w_store_i & !dm_store_done_i -> WAIT_STORE; else stay.
REQ-013 WAIT_LOAD -> IDLE on dm_load_done_i; WAIT_STORE -> IDLE on dm_store_done_i.
REQ-014 w_stall_req_o SHALL be combinational: 1 when w_valid_i and a load (store) is presented or pending and the matching done strobe is 0 this cycle; done in same cycle gives zero-wait, no stall.
REQ-015 rf_rd_write_o SHALL be combinational: w_valid_i & w_rd_write_i & (w_rd_i!=0) & (!w_load_i | dm_load_done_i); exactly one write per instruction.
REQ-016 rf_rd_o SHALL equal w_rd_i; rf_rd_value_o the selected result of REQ-009/010.
REQ-017 On every edge with rf_rd_write_o=1, x_fwd_rd_o/x_fwd_value_o SHALL capture rf_rd_o/rf_rd_value_o and x_fwd_valid_o SHALL be 1; otherwise x_fwd_valid_o SHALL be 0 next cycle, data held.
REQ-018 Writes to x0 SHALL never assert rf_rd_write_o nor x_fwd_valid_o.
REQ-019 Done strobes arriving in IDLE with no matching load/store presented SHALL be ignored.
REQ-020 Simultaneous w_load_i and w_store_i SHALL be treated as a load.

Reset
REQ-021 rst_i SHALL force IDLE, x_fwd_valid_o=0, x_fwd_rd_o=0, x_fwd_value_o=0, w_bus_error_o=0, timeout counter=0, next edge.
REQ-022 Reset mid-WAIT SHALL abandon the access with no register-file write; w_stall_req_o follows inputs combinationally.

Configuration
REQ-023 Macro URV_WB_BUS_TIMEOUT_EN SHALL enable an 8-bit wait counter, cleared on entering WAIT_LOAD/WAIT_STORE, incremented each WAIT cycle.
REQ-024 With macro: counter reaching 255 without done SHALL return to IDLE, pulse w_bus_error_o for 1 cycle, suppress the write, drop w_stall_req_o that cycle.
REQ-025 Without macro: no counter; WAIT states held indefinitely; w_bus_error_o tied 0.

Verification
REQ-026 ALU write: w_rd_i=5, w_rd_value_i=0x1234, source 0, no load -> rf_rd_write_o=1, value 0x1234; next cycle x_fwd_valid_o=1, x_fwd_rd_o=5.
REQ-027 lb at addr 0x...03, dm_data_l_i=0x80FF_FF00, done same cycle -> value 0xFFFF_FF80, no stall; lbu -> 0x0000_0080.
REQ-028 lhu at addr 0x...02, done after 3 cycles with data 0xBEEF_0000 -> stall 3 cycles, one write of 0x0000_BEEF on done cycle.
REQ-029 Write to x0 with value 0xFFFFFFFF -> rf_rd_write_o=0, x_fwd_valid_o stays 0.
REQ-030 Store, dm_store_done_i after 2 cycles -> stall 2 cycles, no rf write, FSM returns IDLE.
REQ-031 Macro enabled, load never completes -> w_bus_error_o pulse 255 cycles after entering WAIT_LOAD, stall released, no write.
